// File: rtl/imem_loader_if.sv
// Byte-stream intake and instruction-memory write port of the boot loader.
// The host drives the byte stream; the loader drives the memory write side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a word-count header, then writes little-endian words to imem; holds the core in reset until done.
// Latency: mem_we one cycle after a word's 4th byte; done/cpu_reset release one cycle after the final write.
// Backpressure: in_ready decoded from state only; high in HDR/LOAD/ERR, low in FLUSH/DONE.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  input  logic          reload,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {S_HDR, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;

  state_t                state, state_nxt;
  logic [1:0]            byte_cnt, byte_cnt_nxt;
  logic [ADDR_WIDTH-1:0] word_idx, word_idx_nxt;
  logic [31:0]           n_words, n_words_nxt;
  logic [23:0]           word_buf, word_buf_nxt;
  logic                  mem_we_nxt;
  logic [31:0]           waddr_nxt, wdata_nxt;
  logic                  cpu_reset_nxt, done_nxt, err_nxt;
  logic                  accept;
  logic [31:0]           hdr_word;
  logic                  last_word;

  assign bus.in_ready = (state == S_HDR) || (state == S_LOAD) || (state == S_ERR);
  assign accept       = bus.in_valid && bus.in_ready;
  assign hdr_word     = {bus.in_data, n_words[31:8]};
  // word_idx never wraps: the final word is detected before incrementing.
  assign last_word    = (32'(word_idx) == (n_words - 32'd1));

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    word_idx_nxt  = word_idx;
    n_words_nxt   = n_words;
    word_buf_nxt  = word_buf;
    mem_we_nxt    = 1'b0;
    waddr_nxt     = bus.mem_waddr;
    wdata_nxt     = bus.mem_wdata;
    cpu_reset_nxt = cpu_reset;
    done_nxt      = done;
    err_nxt       = err;

    case (state)
      S_HDR: begin
        if (accept) begin
          n_words_nxt  = hdr_word;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            word_idx_nxt = '0;
            if (hdr_word > 32'(DEPTH)) begin
              state_nxt = S_ERR;
              err_nxt   = 1'b1;
            end else if (hdr_word == 32'd0) begin
              state_nxt = S_FLUSH;
            end else begin
              state_nxt = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          byte_cnt_nxt = byte_cnt + 2'd1;
          word_buf_nxt = {bus.in_data, word_buf[23:8]};
          if (byte_cnt == 2'd3) begin
            mem_we_nxt = 1'b1;
            wdata_nxt  = {bus.in_data, word_buf};
            waddr_nxt  = 32'({word_idx, 2'b00});
            if (last_word) state_nxt = S_FLUSH;
            else           word_idx_nxt = word_idx + ADDR_WIDTH'(1);
          end
        end
      end
      S_FLUSH: begin
        state_nxt     = S_DONE;
        done_nxt      = 1'b1;
        cpu_reset_nxt = 1'b0;
      end
      S_DONE: begin
        if (reload) begin
          state_nxt     = S_HDR;
          cpu_reset_nxt = 1'b1;
          done_nxt      = 1'b0;
          byte_cnt_nxt  = 2'd0;
          word_idx_nxt  = '0;
          n_words_nxt   = 32'd0;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_HDR;
      byte_cnt      <= 2'd0;
      word_idx      <= '0;
      n_words       <= 32'd0;
      word_buf      <= 24'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= 32'd0;
      bus.mem_wdata <= 32'd0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      byte_cnt      <= byte_cnt_nxt;
      word_idx      <= word_idx_nxt;
      n_words       <= n_words_nxt;
      word_buf      <= word_buf_nxt;
      bus.mem_we    <= mem_we_nxt;
      bus.mem_waddr <= waddr_nxt;
      bus.mem_wdata <= wdata_nxt;
      cpu_reset     <= cpu_reset_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte streams against a stream-format reference model.
module tb_imem_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic cpu_reset, done, err;

  imem_loader_if bus();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .reload    (reload),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] got_addr[$], got_data[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr.push_back(bus.mem_waddr);
      got_data.push_back(bus.mem_wdata);
    end
  end

  // Reference: header word count, then one write per complete payload word.
  task automatic build_expected();
    logic [31:0] n;
    exp_addr.delete();
    exp_data.delete();
    got_addr.delete();
    got_data.delete();
    if (stream.size() < 4) return;
    n = {stream[3], stream[2], stream[1], stream[0]};
    if (n > 32'(DEPTH)) return;
    for (int w = 0; w < int'(n); w++) begin
      if (4 + 4*w + 3 < stream.size()) begin
        exp_addr.push_back(32'(4*w));
        exp_data.push_back({stream[4+4*w+3], stream[4+4*w+2], stream[4+4*w+1], stream[4+4*w]});
      end
    end
  endtask

  task automatic send_stream(input int gap_pct, output bit timed_out, output int drops, output int cycles);
    int   i = 0;
    logic rdy;
    drops  = 0;
    cycles = 0;
    while (i < stream.size() && cycles < 4000) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = stream[i];
      end
      rdy = bus.in_ready;
      if (rdy !== 1'b1) drops++;
      @(posedge clk);
      if (bus.in_valid && rdy) i++;
      cycles++;
    end
    timed_out = (i < stream.size());
  endtask

  // Samples the FLUSH window and the cycle after it.
  task automatic complete_obs(output logic f_rdy, output logic f_done, output logic d_done, output logic d_cpu);
    @(negedge clk);
    bus.in_valid = 1'b0;
    f_rdy  = bus.in_ready;
    f_done = done;
    @(negedge clk);
    d_done = done;
    d_cpu  = cpu_reset;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reload = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== 65'd0) begin
      errors++; $display("FAIL reset_mem we=%b addr=%h data=%h required 0/0/0", bus.mem_we, bus.mem_waddr, bus.mem_wdata);
    end
    checks++;
    if ({cpu_reset, done, err} !== 3'b100) begin
      errors++; $display("FAIL reset_ctl cpu_reset/done/err=%b required 100", {cpu_reset, done, err});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_rdy in_ready=%b required 1", bus.in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to; int drops, cyc, bad; logic fr, fd, dd, dc;
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_expected();
    send_stream(0, to, drops, cyc);
    complete_obs(fr, fd, dd, dc);
    checks++;
    if (to || cyc != stream.size()) begin
      errors++; $display("FAIL basic_throughput cycles=%0d timeout=%0d required %0d/0", cyc, to, stream.size());
    end
    checks++;
    if ({fr, fd} !== 2'b00) begin
      errors++; $display("FAIL basic_flush in_ready/done=%b required 00", {fr, fd});
    end
    checks++;
    if ({dd, dc} !== 2'b10) begin
      errors++; $display("FAIL basic_done done/cpu_reset=%b required 10", {dd, dc});
    end
    bad = (got_addr.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_addr[j]) if (got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_writes got %0d writes (first %h:%h) required %0d (%h:%h)", got_addr.size(),
                         got_addr.size() ? got_addr[0] : 32'hx, got_data.size() ? got_data[0] : 32'hx,
                         exp_addr.size(), exp_addr[0], exp_data[0]);
    end
  endtask

  task automatic test_reload();
    bit to; int drops, cyc, bad; logic fr, fd, dd, dc;
    pulse_reload();
    checks++;
    if ({cpu_reset, done, bus.in_ready} !== 3'b101) begin
      errors++; $display("FAIL reload_ctl cpu_reset/done/in_ready=%b required 101", {cpu_reset, done, bus.in_ready});
    end
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    build_expected();
    send_stream(0, to, drops, cyc);
    complete_obs(fr, fd, dd, dc);
    bad = (got_addr.size() != 1) ? 1 : 0;
    if (bad == 0 && (got_addr[0] !== 32'h0 || got_data[0] !== 32'hDEADBEEF)) bad++;
    checks++;
    if (bad != 0 || {dd, dc} !== 2'b10) begin
      errors++; $display("FAIL reload_write writes=%0d done/cpu_reset=%b required 1 write 00000000:deadbeef and 10",
                         got_addr.size(), {dd, dc});
    end
  endtask

  task automatic test_random_loads(input int iters, input int gap_pct, input bit full_depth);
    bit to; int drops, cyc, bad, n; logic fr, fd, dd, dc;
    for (int it = 0; it < iters; it++) begin
      pulse_reload();
      n = full_depth ? DEPTH : int'($urandom_range(1, 12));
      stream.delete();
      for (int b = 0; b < 4; b++) stream.push_back(8'(n >> (8*b)));
      for (int b = 0; b < 4*n; b++) stream.push_back(8'($urandom));
      if (iters == 1 && !full_depth) begin
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      end
      build_expected();
      send_stream(gap_pct, to, drops, cyc);
      complete_obs(fr, fd, dd, dc);
      checks++;
      if (to || drops != 0) begin
        errors++; $display("FAIL rand_ready it=%0d timeout=%0d ready_drops=%0d required 0/0", it, to, drops);
      end
      bad = (got_addr.size() != exp_addr.size()) ? 1 : 0;
      if (bad == 0) foreach (exp_addr[j]) if (got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand_writes it=%0d n=%0d got %0d writes, %0d differ, required %0d", it, n,
                           got_addr.size(), bad, exp_addr.size());
      end
      checks++;
      if ({fr, fd, dd, dc} !== 4'b0010) begin
        errors++; $display("FAIL rand_done it=%0d flush rdy/done, done/cpu_reset=%b required 0010", it, {fr, fd, dd, dc});
      end
    end
  endtask

  task automatic test_zero();
    bit to; int drops, cyc; logic fr, fd, dd, dc;
    pulse_reload();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    build_expected();
    send_stream(0, to, drops, cyc);
    complete_obs(fr, fd, dd, dc);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL zero_writes got %0d writes required %0d", got_addr.size(), exp_addr.size());
    end
    checks++;
    if ({fr, fd, dd, dc} !== 4'b0010) begin
      errors++; $display("FAIL zero_flush rdy/done, done/cpu_reset=%b required 0010", {fr, fd, dd, dc});
    end
  endtask

  task automatic test_async_reset();
    bit to; int drops, cyc, bad; logic fr, fd, dd, dc;
    pulse_reload();
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    build_expected();
    send_stream(0, to, drops, cyc);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata, cpu_reset, done, err} !== {65'd0, 3'b100}) begin
      errors++; $display("FAIL async_reset we=%b addr=%h data=%h cpu_reset/done/err=%b required 0/0/0/100",
                         bus.mem_we, bus.mem_waddr, bus.mem_wdata, {cpu_reset, done, err});
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_expected();
    send_stream(0, to, drops, cyc);
    complete_obs(fr, fd, dd, dc);
    bad = (got_addr.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_addr[j]) if (got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) bad++;
    checks++;
    if (bad != 0 || {dd, dc} !== 2'b10) begin
      errors++; $display("FAIL async_resend got %0d writes (%0d differ) done/cpu_reset=%b required %0d and 10",
                         got_addr.size(), bad, {dd, dc}, exp_addr.size());
    end
  endtask

  task automatic test_err();
    bit to; int drops, cyc;
    pulse_reload();
    stream = '{8'h01, 8'h01, 8'h00, 8'h00};
    for (int b = 0; b < 16; b++) stream.push_back(8'($urandom));
    build_expected();
    send_stream(0, to, drops, cyc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (to || drops != 0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL err_ready timeout=%0d drops=%0d in_ready=%b required 0/0/1", to, drops, bus.in_ready);
    end
    checks++;
    if ({err, cpu_reset, done} !== 3'b110) begin
      errors++; $display("FAIL err_flags err/cpu_reset/done=%b required 110", {err, cpu_reset, done});
    end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL err_writes got %0d writes required %0d", got_addr.size(), exp_addr.size());
    end
    pulse_reload();
    @(negedge clk);
    checks++;
    if ({err, cpu_reset, bus.in_ready} !== 3'b111) begin
      errors++; $display("FAIL err_reload err/cpu_reset/in_ready=%b required 111", {err, cpu_reset, bus.in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_random_loads(1, 50, 1'b0);
    test_random_loads(4, 30, 1'b0);
    test_random_loads(1, 0, 1'b1);
    test_zero();
    test_async_reset();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
